// File: rtl/accu_16bit_if.sv
// Sample/result bus for accu_16bit.
// The clr abort line exists only when ACCU_CLR_EN is defined.
interface accu_16bit_if #(
    parameter int N = 4
);
    localparam int OUT_W = 16 + $clog2(N);

    logic             valid_in;
    logic [15:0]      data_in;
    logic             valid_out;
    logic [OUT_W-1:0] data_out;
`ifdef ACCU_CLR_EN
    logic             clr;
`endif

    // Producer side: drives samples and observes group sums.
    modport master (
        output valid_in,
        output data_in,
`ifdef ACCU_CLR_EN
        output clr,
`endif
        input  valid_out,
        input  data_out
    );

    // Accumulator side.
    modport slave (
        input  valid_in,
        input  data_in,
`ifdef ACCU_CLR_EN
        input  clr,
`endif
        output valid_out,
        output data_out
    );
endinterface

// File: rtl/accu_16bit.sv
// accu_16bit: sums groups of N unsigned 16-bit samples and emits one
// OUT_W-bit result per group, with a one-cycle valid_out pulse.
// Optional feature: define ACCU_CLR_EN to add a synchronous group abort (clr).
// Reset is synchronous and active-low.
module accu_16bit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    accu_16bit_if.slave  bus
);
    localparam int OUT_W = 16 + $clog2(N);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             vout_q, vout_d;
    logic [OUT_W-1:0] sum;

    // State register: all state updates on the rising edge, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
        end
    end

    // Next-state logic: take a sample when valid, close the group on the Nth.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vout_d  = 1'b0;
        sum     = acc_q + OUT_W'(bus.data_in);

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    acc_d   = OUT_W'(bus.data_in);
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.valid_in) begin
                    if (cnt_q == LAST) begin
                        dout_d  = sum;
                        vout_d  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase

`ifdef ACCU_CLR_EN
        // Abort wins over any same-cycle sample, including a group's last one;
        // the previously published result stays on data_out.
        if (bus.clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            dout_d  = dout_q;
            vout_d  = 1'b0;
        end
`endif
    end

    assign bus.valid_out = vout_q;
    assign bus.data_out  = dout_q;
endmodule

// File: doc/accu_16bit.md
ACCU_16BIT -- requirements
Module: accu_16bit

Interface
REQ-001 SHALL provide parameter: N, 4, number of 16-bit samples summed per group (legal 2..16).
REQ-002 SHALL provide derived localparam: OUT_W, 16+clog2(N), result width (18 for N=4).
REQ-003 SHALL provide port: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL provide port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port: valid_in  input  1  data_in qualifier, one sample per cycle when high.
REQ-006 SHALL provide port: data_in  input  16  unsigned sample, typically the 16-bit adder sum.
REQ-007 SHALL provide port: valid_out  output  1  one-cycle pulse, data_out holds a new group sum.
REQ-008 SHALL provide port: data_out  output  OUT_W  unsigned sum of last completed group.
REQ-009 SHALL provide port: clr  input  1  synchronous group abort; present only with ACCU_CLR_EN.

Function
REQ-010 SHALL hold acc (OUT_W bits) and sample counter cnt (clog2(N) bits, range 0..N-1).
REQ-011 SHALL implement two states: IDLE (cnt==0, no partial sum) and ACCUM (1..N-1 samples taken).
REQ-012 SHALL in IDLE with valid_in: acc <= zero-extended data_in, cnt <= 1, go ACCUM.
REQ-013 SHALL in ACCUM with valid_in and cnt<N-1: acc <= acc+data_in, cnt <= cnt+1.
REQ-014 SHALL in ACCUM with valid_in and cnt==N-1: data_out <= acc+data_in, valid_out <= 1 next cycle, cnt <= 0, go IDLE.
REQ-015 SHALL with valid_in low: hold acc, cnt, state; gaps of any length allowed mid-group.
REQ-016 SHALL assert valid_out exactly one cycle after the cycle carrying the Nth sample, for exactly one cycle.
REQ-017 SHALL accept a new group's first sample in the cycle valid_out is high; back-to-back groups give one pulse every N cycles.
REQ-018 SHALL never overflow: OUT_W bits hold N*0xFFFF exactly; additions are unsigned, zero-extended.
REQ-019 SHALL hold data_out stable between pulses; valid_out low otherwise.
REQ-020 SHALL apply no input backpressure; every valid_in cycle consumes one sample.

Reset
REQ-021 SHALL on rst_n low at a clock edge: acc=0, cnt=0, state IDLE, valid_out=0, data_out=0.
REQ-022 SHALL discard any partial group on reset; rst_n overrides valid_in and clr.
REQ-023 SHALL start a fresh group with the first valid_in after rst_n returns high.

Configuration
REQ-024 SHALL use macro ACCU_CLR_EN to compile in clr port and logic.
REQ-025 SHALL with ACCU_CLR_EN, clr high: cnt=0, state IDLE, acc=0, valid_out=0 next cycle, data_out retained; clr beats a same-cycle valid_in (sample dropped), including an Nth sample.
REQ-026 SHALL without ACCU_CLR_EN: no clr port; groups end only by N samples or reset.

Verification
REQ-027 SHALL check: N=4, samples 1,2,3,4 on consecutive cycles -> valid_out one cycle after sample 4, data_out=10.
REQ-028 SHALL check: four samples 0xFFFF -> data_out=0x3FFFC, no truncation.
REQ-029 SHALL check: samples 14,1,999,0 with 2-cycle valid_in gaps -> one pulse, data_out=1014, no early pulse.
REQ-030 SHALL check: eight back-to-back samples 1..8 -> pulses 4 cycles apart, data_out=10 then 26.
REQ-031 SHALL check: samples 5,5, rst_n low one cycle, then 1,1,1,1 -> data_out=4, no pulse for partial group.
REQ-032 SHALL check (ACCU_CLR_EN): samples 7,7,7 then clr with sample 7 -> no pulse; next 2,2,2,2 -> data_out=8.
